// File: rtl/mux_select_arbiter_if.sv
// Request/grant bundle between the requesters and the 4:1 mux arbiter.
// The lock signal exists only when MUX_ARB_LOCK_EN is defined.
interface mux_select_arbiter_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] select;
    logic       valid;
`ifdef MUX_ARB_LOCK_EN
    logic       lock;
`endif

    modport master (
        output req,
`ifdef MUX_ARB_LOCK_EN
        output lock,
`endif
        input  gnt,
        input  select,
        input  valid
    );

    modport slave (
        input  req,
`ifdef MUX_ARB_LOCK_EN
        input  lock,
`endif
        output gnt,
        output select,
        output valid
    );
endinterface

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 8-bit mux, with bounded hold and a dead gap.
// Optional feature macro: MUX_ARB_LOCK_EN (owner may extend its hold with lock).
//
// state   | meaning
// IDLE    | nobody owns the mux, waiting for any request
// GRANT   | one owner drives the mux, hold counter running
// RELEASE | one-cycle dead gap between owners
module mux_select_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    mux_select_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state, state_n;
    logic [3:0]       gnt, gnt_n;
    logic [1:0]       select, select_n;
    logic [1:0]       last, last_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             lock_hold;
    logic             contend;
    logic [1:0]       winner;

`ifdef MUX_ARB_LOCK_EN
    assign lock_hold = bus.lock;
`else
    assign lock_hold = 1'b0;
`endif

    // Scan downward so the nearest set bit after 'l' is the last one written.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
        logic [1:0] idx;
        rr_pick = l;
        for (int k = 4; k >= 1; k--) begin
            idx = l + 2'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    assign winner  = rr_pick(bus.req, last);
    assign contend = |(bus.req & ~gnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            gnt    <= 4'b0000;
            select <= 2'b00;
            last   <= 2'd3;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            gnt    <= gnt_n;
            select <= select_n;
            last   <= last_n;
            cnt    <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        gnt_n    = gnt;
        select_n = select;
        last_n   = last;
        cnt_n    = cnt;
        case (state)
            IDLE, RELEASE: begin
                if (|bus.req) begin
                    state_n  = GRANT;
                    gnt_n    = 4'b0001 << winner;
                    select_n = winner;
                    cnt_n    = '0;
                end else begin
                    state_n = IDLE;
                    gnt_n   = 4'b0000;
                end
            end
            GRANT: begin
                if (!bus.req[select] ||
                    (cnt == HOLD_LAST && contend && !lock_hold)) begin
                    state_n = RELEASE;
                    gnt_n   = 4'b0000;
                    last_n  = select;
                end else if (cnt != HOLD_LAST) begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 4'b0000;
            end
        endcase
    end

    assign bus.gnt    = gnt;
    assign bus.select = select;
    assign bus.valid  = |gnt;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Scenario bench for mux_select_arbiter (MAX_HOLD=4); expected outputs are queued per driven cycle.
module tb_mux_select_arbiter;

    localparam int MH = 4;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [6:0] exp_q[$];
    logic [6:0] e;

    mux_select_arbiter_if bus();

    mux_select_arbiter #(.MAX_HOLD(MH), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Apply inputs after the sampling edge, then wait past the next rising edge.
    task automatic drive(input logic rst_v, input logic [3:0] r, input logic [3:0] eg, input logic [1:0] es);
        reset   = rst_v;
        bus.req = r;
        exp_q.push_back({eg, es, |eg});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'b1111, 4'b0000, 2'b00);
            e = exp_q.pop_front(); total++;
            if ({bus.gnt, bus.select, bus.valid} !== e) begin
                bad++;
                $display("FAIL reset cyc%0d: got gnt=%b sel=%b valid=%b want %b", i, bus.gnt, bus.select, bus.valid, e);
            end
        end
    endtask

    task automatic test_single();
        for (int i = 0; i < 8; i++) begin
            if (i < 5) drive(1'b0, 4'b0100, 4'b0100, 2'd2);
            else       drive(1'b0, 4'b0000, 4'b0000, 2'd2);
            e = exp_q.pop_front(); total++;
            if ({bus.gnt, bus.select, bus.valid} !== e) begin
                bad++;
                $display("FAIL single cyc%0d: got gnt=%b sel=%b valid=%b want %b", i, bus.gnt, bus.select, bus.valid, e);
            end
        end
    endtask

    task automatic test_lone_hold();
        for (int i = 0; i < 22; i++) begin
            if (i < 20) drive(1'b0, 4'b0010, 4'b0010, 2'd1);
            else        drive(1'b0, 4'b0000, 4'b0000, 2'd1);
            e = exp_q.pop_front(); total++;
            if ({bus.gnt, bus.select, bus.valid} !== e) begin
                bad++;
                $display("FAIL lone_hold cyc%0d: got gnt=%b sel=%b valid=%b want %b", i, bus.gnt, bus.select, bus.valid, e);
            end
        end
    endtask

    // Each owner gets MH grant cycles then a gap; 'n' cycles of the pattern, starting after a reset.
    task automatic run_round_robin(input int n, input string tag);
        int g, p;
        drive(1'b1, 4'b0000, 4'b0000, 2'd0);
        for (int i = 0; i <= n; i++) begin
            if (i > 0) begin
                g = ((i - 1) / (MH + 1)) % 4;
                p = (i - 1) % (MH + 1);
                if (p < MH) drive(1'b0, 4'b1111, 4'(1 << g), 2'(g));
                else        drive(1'b0, 4'b1111, 4'b0000, 2'(g));
            end
            e = exp_q.pop_front(); total++;
            if ({bus.gnt, bus.select, bus.valid} !== e) begin
                bad++;
                $display("FAIL %s cyc%0d: got gnt=%b sel=%b valid=%b want %b", tag, i, bus.gnt, bus.select, bus.valid, e);
            end
        end
    endtask

    task automatic test_round_robin();
        run_round_robin(4 * (MH + 1) + 1, "round_robin");
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 4'b0000, 4'b0000, 2'd0);
            e = exp_q.pop_front(); total++;
            if ({bus.gnt, bus.select, bus.valid} !== e) begin
                bad++;
                $display("FAIL rr_drain cyc%0d: got gnt=%b sel=%b valid=%b want %b", i, bus.gnt, bus.select, bus.valid, e);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        run_round_robin(3 * (MH + 1) + 1, "mid_grant_pre");
        if (bus.gnt !== 4'b1000) begin
            bad++;
            $display("FAIL mid_grant_owner: got gnt=%b want 1000", bus.gnt);
        end
        total++;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: drive(1'b1, 4'b1111, 4'b0000, 2'd0);
                1: drive(1'b0, 4'b1111, 4'b0001, 2'd0);
                default: drive(1'b0, 4'b0000, 4'b0000, 2'd0);
            endcase
            e = exp_q.pop_front(); total++;
            if ({bus.gnt, bus.select, bus.valid} !== e) begin
                bad++;
                $display("FAIL mid_grant cyc%0d: got gnt=%b sel=%b valid=%b want %b", i, bus.gnt, bus.select, bus.valid, e);
            end
        end
    endtask

    // Owner drops early with a waiter, then a lone requester is re-picked after the gap.
    task automatic test_back_to_back();
        logic [3:0] r_t [8] = '{4'b0011, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        logic [3:0] g_t [8] = '{4'b0010, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        logic [1:0] s_t [8] = '{2'd1,    2'd1,    2'd0,    2'd0,    2'd0,    2'd0,    2'd0,    2'd0};
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, r_t[i], g_t[i], s_t[i]);
            e = exp_q.pop_front(); total++;
            if ({bus.gnt, bus.select, bus.valid} !== e) begin
                bad++;
                $display("FAIL back_to_back cyc%0d: got gnt=%b sel=%b valid=%b want %b", i, bus.gnt, bus.select, bus.valid, e);
            end
        end
    endtask

`ifdef MUX_ARB_LOCK_EN
    task automatic test_lock();
        drive(1'b1, 4'b0000, 4'b0000, 2'd0);
        void'(exp_q.pop_front());
        bus.lock = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 6) bus.lock = 1'b0;
            if (i < 6)       drive(1'b0, 4'b0011, 4'b0001, 2'd0);
            else if (i == 6) drive(1'b0, 4'b0011, 4'b0000, 2'd0);
            else if (i == 7) drive(1'b0, 4'b0011, 4'b0010, 2'd1);
            else             drive(1'b0, 4'b0000, 4'b0000, 2'd1);
            e = exp_q.pop_front(); total++;
            if ({bus.gnt, bus.select, bus.valid} !== e) begin
                bad++;
                $display("FAIL lock cyc%0d: got gnt=%b sel=%b valid=%b want %b", i, bus.gnt, bus.select, bus.valid, e);
            end
        end
    endtask
`endif

    initial begin
        reset   = 1'b1;
        bus.req = 4'b0000;
`ifdef MUX_ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_single();
        test_lone_hold();
        test_round_robin();
        test_reset_mid_grant();
        test_back_to_back();
`ifdef MUX_ARB_LOCK_EN
        test_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
